// File: rtl/score_overlay_if.sv
// Pixel/score bus between the game logic and the score overlay.
// The master drives pixel coordinates and score events; the slave returns the overlay bit and score.
interface score_overlay_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic [209:0]  text_bits;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_valid;
    logic          frame_start;
    logic          score_inc;
    logic          score_clr;
    logic          pix_on;
    logic          pix_on_valid;
    logic [11:0]   score_bcd;
    logic          score_sat;

    modport master (
        output text_bits, pix_x, pix_y, pix_valid, frame_start, score_inc, score_clr,
        input  pix_on, pix_on_valid, score_bcd, score_sat
    );

    modport slave (
        input  text_bits, pix_x, pix_y, pix_valid, frame_start, score_inc, score_clr,
        output pix_on, pix_on_valid, score_bcd, score_sat
    );
endinterface

// File: rtl/score_overlay.sv
// "SCORE" label plus 3-digit BCD score rendered as a 2-cycle pipelined per-pixel overlay bit.
// The score is shadowed once per frame so the digits never change mid-frame.
module score_overlay #(
    parameter int X0         = 8,
    parameter int Y0         = 8,
    parameter int SCALE_LOG2 = 2,
    parameter int XW         = 10,
    parameter int YW         = 9
) (
    input  logic            clk,
    input  logic            reset,
    score_overlay_if.slave  ovl
);

    // Row r of a digit glyph; leftmost glyph column is bit 4. Codes 10-15 are blank.
    function automatic logic [4:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
        logic [29:0] g;
        logic [4:0]  row;
        case (d)
            4'd0:    g = 30'b01110_10001_10001_10001_10001_01110;
            4'd1:    g = 30'b00100_01100_00100_00100_00100_01110;
            4'd2:    g = 30'b01110_10001_00010_00100_01000_11111;
            4'd3:    g = 30'b11110_00001_01110_00001_00001_11110;
            4'd4:    g = 30'b00010_00110_01010_10010_11111_00010;
            4'd5:    g = 30'b11111_10000_11110_00001_00001_11110;
            4'd6:    g = 30'b01110_10000_11110_10001_10001_01110;
            4'd7:    g = 30'b11111_00001_00010_00100_01000_01000;
            4'd8:    g = 30'b01110_10001_01110_10001_10001_01110;
            4'd9:    g = 30'b01110_10001_10001_01111_00001_01110;
            default: g = 30'b0;
        endcase
        case (r)
            3'd0:    row = g[29:25];
            3'd1:    row = g[24:20];
            3'd2:    row = g[19:15];
            3'd3:    row = g[14:10];
            3'd4:    row = g[9:5];
            3'd5:    row = g[4:0];
            default: row = 5'b0;
        endcase
        return row;
    endfunction

    // Decimal increment of a 3-digit BCD value below 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    logic [11:0]   score_q, score_d;
    logic          sat_q, sat_d;
    logic [11:0]   shadow_q, shadow_d;

    logic [XW-1:0] dx_s, lx_full_s;
    logic [YW-1:0] dy_s, ly_full_s;
    logic          in_region_s;
    logic [5:0]    lx_s, t_s;
    logic [1:0]    dsel_s;
    logic [2:0]    dcol_s;

    logic          valid1_q, in_region1_q;
    logic [5:0]    lx1_q;
    logic [2:0]    ly1_q;
    logic [1:0]    dsel1_q;
    logic [2:0]    dcol1_q;

    logic [7:0]    text_idx_s;
    logic [3:0]    digit_s;
    logic [4:0]    row_s;
    logic          bit_s;
    logic          pix_on_q, pix_on_d;
    logic          valid2_q;

    // Score counter and frame shadow next state.
    always_comb begin
        score_d  = score_q;
        sat_d    = sat_q;
        shadow_d = shadow_q;
        if (ovl.score_clr) begin
            score_d  = 12'h000;
            sat_d    = 1'b0;
            shadow_d = 12'h000;
        end else begin
            if (ovl.frame_start) begin
                shadow_d = score_q;
            end else begin
                shadow_d = shadow_q;
            end
            if (ovl.score_inc) begin
                if (score_q == 12'h999) begin
                    sat_d = 1'b1;
                end else begin
                    score_d = bcd_inc(score_q);
                end
            end else begin
                score_d = score_q;
            end
        end
    end

    // Stage 1 combinational: region test and logical grid coordinates.
    always_comb begin
        dx_s        = ovl.pix_x - XW'(X0);
        dy_s        = ovl.pix_y - YW'(Y0);
        lx_full_s   = dx_s >> SCALE_LOG2;
        ly_full_s   = dy_s >> SCALE_LOG2;
        in_region_s = (ovl.pix_x >= XW'(X0)) && (ovl.pix_y >= YW'(Y0)) &&
                      (lx_full_s < XW'(54)) && (ly_full_s < YW'(6));
        lx_s        = lx_full_s[5:0];
        t_s         = 6'd0;
        dsel_s      = 2'd3;
        dcol_s      = 3'd0;
        if (lx_s >= 6'd36) begin
            t_s = lx_s - 6'd36;
            if (t_s < 6'd6) begin
                dsel_s = 2'd0;
                dcol_s = t_s[2:0];
            end else if (t_s < 6'd12) begin
                dsel_s = 2'd1;
                dcol_s = 3'(t_s - 6'd6);
            end else begin
                dsel_s = 2'd2;
                dcol_s = 3'(t_s - 6'd12);
            end
        end else begin
            t_s = 6'd0;
        end
    end

    // Stage 2 combinational: pick label bit or glyph bit.
    always_comb begin
        text_idx_s = ({5'd0, ly1_q} * 8'd35) + {2'd0, lx1_q};
        case (dsel1_q)
            2'd0:    digit_s = shadow_q[11:8];
            2'd1:    digit_s = shadow_q[7:4];
            2'd2:    digit_s = shadow_q[3:0];
            default: digit_s = 4'd15;
        endcase
        row_s = glyph_row(digit_s, ly1_q);
        if (lx1_q < 6'd35) begin
            bit_s = ovl.text_bits[text_idx_s];
        end else if ((dsel1_q != 2'd3) && (dcol1_q < 3'd5)) begin
            bit_s = row_s[3'd4 - dcol1_q];
        end else begin
            bit_s = 1'b0;
        end
        pix_on_d = valid1_q & in_region1_q & bit_s;
    end

    // Score, shadow and both pipeline stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q      <= 12'h000;
            sat_q        <= 1'b0;
            shadow_q     <= 12'h000;
            valid1_q     <= 1'b0;
            in_region1_q <= 1'b0;
            lx1_q        <= 6'd0;
            ly1_q        <= 3'd0;
            dsel1_q      <= 2'd3;
            dcol1_q      <= 3'd0;
            pix_on_q     <= 1'b0;
            valid2_q     <= 1'b0;
        end else begin
            score_q      <= score_d;
            sat_q        <= sat_d;
            shadow_q     <= shadow_d;
            valid1_q     <= ovl.pix_valid;
            in_region1_q <= in_region_s;
            lx1_q        <= lx_s;
            ly1_q        <= ly_full_s[2:0];
            dsel1_q      <= dsel_s;
            dcol1_q      <= dcol_s;
            pix_on_q     <= pix_on_d;
            valid2_q     <= valid1_q;
        end
    end

    assign ovl.pix_on       = pix_on_q;
    assign ovl.pix_on_valid = valid2_q;
    assign ovl.score_bcd    = score_q;
    assign ovl.score_sat    = sat_q;

endmodule

// File: tb/tb_score_overlay.sv
// Randomized and directed bench for score_overlay against an integer-level model
// of the score counter, frame shadow and overlay image.
module tb_score_overlay;
    localparam int XW = 10;
    localparam int YW = 9;

    localparam logic [29:0] FONT [10] = '{
        30'b01110_10001_10001_10001_10001_01110,
        30'b00100_01100_00100_00100_00100_01110,
        30'b01110_10001_00010_00100_01000_11111,
        30'b11110_00001_01110_00001_00001_11110,
        30'b00010_00110_01010_10010_11111_00010,
        30'b11111_10000_11110_00001_00001_11110,
        30'b01110_10000_11110_10001_10001_01110,
        30'b11111_00001_00010_00100_01000_01000,
        30'b01110_10001_01110_10001_10001_01110,
        30'b01110_10001_10001_01111_00001_01110
    };

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_overlay_if #(.XW(XW), .YW(YW)) ovl ();

    score_overlay #(.X0(8), .Y0(8), .SCALE_LOG2(2), .XW(XW), .YW(YW)) dut (
        .clk   (clk),
        .reset (reset),
        .ovl   (ovl.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int   m_score, m_shadow, pend_x, pend_y;
    bit   m_sat, m_valid, m_on, pend_v;
    logic [209:0] text;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // What the overlay must show at screen pixel (x,y) for a given displayed score.
    function automatic bit lit(input int x, input int y, input int shadow, input logic [209:0] tb);
        int lx, ly, t, d, c, dig;
        logic [29:0] g;
        if (x < 8 || y < 8) return 1'b0;
        lx = (x - 8) / 4;
        ly = (y - 8) / 4;
        if (lx >= 54 || ly >= 6) return 1'b0;
        if (lx < 35) return tb[35 * ly + lx];
        if (lx == 35) return 1'b0;
        t = lx - 36;
        d = t / 6;
        c = t % 6;
        if (c == 5) return 1'b0;
        dig = (d == 0) ? shadow / 100 : (d == 1) ? (shadow / 10) % 10 : shadow % 10;
        g = FONT[dig];
        return g[29 - 5 * ly - c];
    endfunction

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_shadow = 0; m_sat = 1'b0;
        m_valid = 1'b0; m_on = 1'b0; pend_v = 1'b0; pend_x = 0; pend_y = 0;
    endtask

    // One clock: the model consumes the inputs sampled at this edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            m_valid = pend_v;
            m_on    = pend_v && lit(pend_x, pend_y, m_shadow, text);
            pend_v  = ovl.pix_valid;
            pend_x  = int'(ovl.pix_x);
            pend_y  = int'(ovl.pix_y);
            if (ovl.score_clr) begin
                m_score = 0; m_sat = 1'b0; m_shadow = 0;
            end else begin
                if (ovl.frame_start) m_shadow = m_score;
                if (ovl.score_inc) begin
                    if (m_score == 999) m_sat = 1'b1;
                    else m_score++;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input int x, input int y, input bit fs, input bit inc, input bit clr);
        ovl.pix_valid   = v;
        ovl.pix_x       = XW'(x);
        ovl.pix_y       = YW'(y);
        ovl.frame_start = fs;
        ovl.score_inc   = inc;
        ovl.score_clr   = clr;
        tick();
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic probe(input string nm, input int x, input int y, input bit exp);
        drive(1'b1, x, y, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        check(nm, 12'(ovl.pix_on), 12'(exp));
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("pix_on_valid", 12'(ovl.pix_on_valid), 12'(m_valid));
            if (m_valid) check("pix_on", 12'(ovl.pix_on), 12'(m_on));
            check("score_bcd", ovl.score_bcd, to_bcd(m_score));
            check("score_sat", 12'(ovl.score_sat), 12'(m_sat));
        end
    end

    initial begin
        for (int i = 0; i < 210; i++) text[i] = 1'($urandom_range(0, 1));
        text[0] = 1'b1;
        ovl.text_bits = text;
        reset = 1'b1;
        ovl.pix_valid = 1'b0; ovl.pix_x = '0; ovl.pix_y = '0;
        ovl.frame_start = 1'b0; ovl.score_inc = 1'b0; ovl.score_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;
        check("rst_bcd", ovl.score_bcd, 12'h000);
        check("rst_valid", 12'(ovl.pix_on_valid), 12'h000);
        check("rst_on", 12'(ovl.pix_on), 12'h000);

        incs(5);
        check("inc5", ovl.score_bcd, 12'h005);
        check("shadow_pre", 12'(m_shadow), 12'h000);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        check("shadow_post", 12'(m_shadow), 12'h005);

        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        incs(99);
        check("s099", ovl.score_bcd, 12'h099);
        incs(1);
        check("s100", ovl.score_bcd, 12'h100);

        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        incs(999);
        check("s999", ovl.score_bcd, 12'h999);
        check("sat0", 12'(ovl.score_sat), 12'h000);
        incs(2);
        check("s999hold", ovl.score_bcd, 12'h999);
        check("sat1", 12'(ovl.score_sat), 12'h001);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("clr_bcd", ovl.score_bcd, 12'h000);
        check("clr_sat", 12'(ovl.score_sat), 12'h000);

        incs(42);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        check("clr_wins", ovl.score_bcd, 12'h000);
        incs(7);
        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        check("fs_inc_live", ovl.score_bcd, 12'h008);
        check("fs_inc_shadow", 12'(m_shadow), 12'h007);

        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        incs(10);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        probe("px_8_8", 8, 8, 1'b1);
        probe("px_7_8", 7, 8, 1'b0);
        probe("px_224_8", 224, 8, 1'b0);
        probe("hund_152", 152, 8, 1'b0);
        probe("hund_156", 156, 8, 1'b1);
        probe("tens_176", 176, 12, 1'b0);
        probe("tens_180", 180, 12, 1'b1);
        for (int y = 8; y < 12; y++)
            for (int x = 152; x < 172; x++) drive(1'b1, x, y, 1'b0, 1'b0, 1'b0);
        for (int x = 176; x < 200; x++) drive(1'b1, x, 12, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while the overlay is lit.
        incs(3);
        drive(1'b1, 8, 8, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8, 8, 1'b0, 1'b0, 1'b0);
        check("pre_rst_on", 12'(ovl.pix_on), 12'h001);
        #1 reset = 1'b1;
        #1;
        check("arst_on", 12'(ovl.pix_on), 12'h000);
        check("arst_valid", 12'(ovl.pix_on_valid), 12'h000);
        check("arst_bcd", ovl.score_bcd, 12'h000);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 240), $urandom_range(0, 40),
                  $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 199) == 0);
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
